// File: rtl/sound_sdr_arbiter.sv
// sound_sdr_arbiter
//   Shares the single SDRAM read port of the sound board between two clients
//   (client 0: GA20 sample cache, client 1: second sound ROM fetcher). One
//   transaction in flight at a time; the granted address is forwarded and the
//   returned data is steered to the granted client with a one-cycle ready pulse.
//   Single clock domain (clk_ram).
//
// Ports
//   clk_ram      SDRAM-side clock, rising edge
//   reset_n      asynchronous active-low reset
//   c0_req/c1_req    client request levels (address stable while high)
//   c0_addr/c1_addr  client addresses
//   c0_data/c1_data  registered read data, held until that client's next completion
//   c0_rdy/c1_rdy    one-cycle pulse, data valid
//   sdr_req      request to the SDRAM controller, held until sdr_rdy or timeout
//   sdr_addr     registered address, stable while sdr_req high
//   sdr_data     SDRAM read data, valid with sdr_rdy
//   sdr_rdy      one-cycle completion strobe from the controller
//   busy         high while a transaction is in WAIT or RECOVER
//   timeout_err  one-cycle pulse when a transaction is aborted by the timer
module sound_sdr_arbiter #(
  parameter int unsigned AW         = 25,
  parameter int unsigned DW         = 64,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic          clk_ram,
  input  logic          reset_n,
  input  logic          c0_req,
  input  logic [AW-1:0] c0_addr,
  output logic [DW-1:0] c0_data,
  output logic          c0_rdy,
  input  logic          c1_req,
  input  logic [AW-1:0] c1_addr,
  output logic [DW-1:0] c1_data,
  output logic          c1_rdy,
  output logic          sdr_req,
  output logic [AW-1:0] sdr_addr,
  input  logic [DW-1:0] sdr_data,
  input  logic          sdr_rdy,
  output logic          busy,
  output logic          timeout_err
);

  localparam int unsigned   TW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RECOVER
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_start;
  logic          w_done;
  logic          w_tmo;
  logic          w_sel;
  logic          w_tmo_hit;
  logic [DW-1:0] w_rdata;

  logic          r_last;
  logic          r_grant;
  logic [TW-1:0] r_timer;
  logic          r_sdr_req;
  logic [AW-1:0] r_sdr_addr;
  logic [DW-1:0] r_c0_data;
  logic [DW-1:0] r_c1_data;
  logic          r_c0_rdy;
  logic          r_c1_rdy;
  logic          r_terr;

  assign w_tmo_hit = (TIMEOUT != 0) && (r_timer == T_LAST);
  assign w_rdata   = w_tmo ? '1 : sdr_data;

  // A lone requester wins outright; a tie goes to client 0 in fixed mode,
  // otherwise to the client not granted last time.
  always_comb begin
    w_sel = c1_req;
    if (c0_req && c1_req) begin
      w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end
  end

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // sdr_rdy wins over a coinciding timeout, so it is tested first.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (c0_req || c1_req) begin
          w_start = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sdr_rdy) begin
          w_done = 1'b1;
          w_next = S_RECOVER;
        end else if (w_tmo_hit) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
          w_next = S_RECOVER;
        end
      end
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_timer    <= '0;
      r_sdr_req  <= 1'b0;
      r_sdr_addr <= '0;
      r_c0_data  <= '0;
      r_c1_data  <= '0;
      r_c0_rdy   <= 1'b0;
      r_c1_rdy   <= 1'b0;
      r_terr     <= 1'b0;
    end else begin
      r_c0_rdy <= 1'b0;
      r_c1_rdy <= 1'b0;
      r_terr   <= 1'b0;
      if (w_start) begin
        r_sdr_req  <= 1'b1;
        r_sdr_addr <= w_sel ? c1_addr : c0_addr;
        r_grant    <= w_sel;
        r_last     <= w_sel;
        r_timer    <= '0;
      end
      // Saturating count of WAIT cycles without completion.
      if ((r_state == S_WAIT) && !sdr_rdy && (r_timer != '1)) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_done) begin
        r_sdr_req <= 1'b0;
        r_terr    <= w_tmo;
        if (r_grant) begin
          r_c1_data <= w_rdata;
          r_c1_rdy  <= 1'b1;
        end else begin
          r_c0_data <= w_rdata;
          r_c0_rdy  <= 1'b1;
        end
      end
    end
  end

  assign sdr_req     = r_sdr_req;
  assign sdr_addr    = r_sdr_addr;
  assign c0_data     = r_c0_data;
  assign c1_data     = r_c1_data;
  assign c0_rdy      = r_c0_rdy;
  assign c1_rdy      = r_c1_rdy;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_sound_sdr_arbiter.sv
// Bench for sound_sdr_arbiter: instance 0 is round-robin with TIMEOUT=16,
// instance 1 is fixed priority with the timeout disabled. A transaction-level
// model (winner choice, last grant, per-client held data) predicts every result.
module tb_sound_sdr_arbiter;
  localparam int AW = 25;
  localparam int DW = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          c0_req[2], c1_req[2], sdr_rdy[2];
  logic [AW-1:0] c0_addr[2], c1_addr[2], sdr_addr[2];
  logic [DW-1:0] sdr_data[2], c0_data[2], c1_data[2];
  logic          c0_rdy[2], c1_rdy[2], sdr_req[2], busy[2], terr[2];

  int checks = 0;
  int passed = 0;

  // model state
  int            last_g[2];
  logic [DW-1:0] exp_d[2][2];

  sound_sdr_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT(16)) u_rr (
    .clk_ram(clk), .reset_n(rst_n),
    .c0_req(c0_req[0]), .c0_addr(c0_addr[0]), .c0_data(c0_data[0]), .c0_rdy(c0_rdy[0]),
    .c1_req(c1_req[0]), .c1_addr(c1_addr[0]), .c1_data(c1_data[0]), .c1_rdy(c1_rdy[0]),
    .sdr_req(sdr_req[0]), .sdr_addr(sdr_addr[0]), .sdr_data(sdr_data[0]), .sdr_rdy(sdr_rdy[0]),
    .busy(busy[0]), .timeout_err(terr[0])
  );

  sound_sdr_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT(0)) u_fx (
    .clk_ram(clk), .reset_n(rst_n),
    .c0_req(c0_req[1]), .c0_addr(c0_addr[1]), .c0_data(c0_data[1]), .c0_rdy(c0_rdy[1]),
    .c1_req(c1_req[1]), .c1_addr(c1_addr[1]), .c1_data(c1_data[1]), .c1_rdy(c1_rdy[1]),
    .sdr_req(sdr_req[1]), .sdr_addr(sdr_addr[1]), .sdr_data(sdr_data[1]), .sdr_rdy(sdr_rdy[1]),
    .busy(busy[1]), .timeout_err(terr[1])
  );

  function automatic int pick(input int d, input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (d == 1) return 0;
    return 1 - last_g[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_g[d]   = 1;
      exp_d[d][0] = '0;
      exp_d[d][1] = '0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      c0_req[d] = 1'b0; c1_req[d] = 1'b0; sdr_rdy[d] = 1'b0;
      c0_addr[d] = '0;  c1_addr[d] = '0;  sdr_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Starts in an IDLE cycle with requests already driven; returns in the IDLE
  // cycle after RECOVER. got = client that pulsed rdy (-1 if none).
  task automatic txn(input int d, input int delay, input logic [DW-1:0] data,
                     input bit drop, input bit stray, output int got);
    int w;
    logic [AW-1:0] ea;
    w  = pick(d, c0_req[d], c1_req[d]);
    ea = (w == 0) ? c0_addr[d] : c1_addr[d];
    last_g[d] = w;
    sdr_rdy[d] = stray;
    @(posedge clk); #1;
    sdr_rdy[d] = 1'b0;
    checks++;
    if (sdr_req[d] !== 1'b1 || busy[d] !== 1'b1 || sdr_addr[d] !== ea || c0_rdy[d] !== 1'b0 || c1_rdy[d] !== 1'b0)
      $display("FAIL grant d%0d: req=%b busy=%b addr=%h rdy=%b%b, want 1 1 %h 00",
               d, sdr_req[d], busy[d], sdr_addr[d], c0_rdy[d], c1_rdy[d], ea);
    else passed++;
    if (drop) begin
      if (w == 0) c0_req[d] = 1'b0; else c1_req[d] = 1'b0;
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      checks++;
      if (sdr_req[d] !== 1'b1 || sdr_addr[d] !== ea || c0_rdy[d] !== 1'b0 || c1_rdy[d] !== 1'b0 || terr[d] !== 1'b0)
        $display("FAIL wait d%0d cyc %0d: req=%b addr=%h rdy=%b%b terr=%b, want 1 %h 00 0",
                 d, i, sdr_req[d], sdr_addr[d], c0_rdy[d], c1_rdy[d], terr[d], ea);
      else passed++;
    end
    sdr_rdy[d]  = 1'b1;
    sdr_data[d] = data;
    @(posedge clk); #1;
    sdr_rdy[d]  = stray;
    sdr_data[d] = {$urandom(), $urandom()};
    exp_d[d][w] = data;
    got = c0_rdy[d] ? 0 : (c1_rdy[d] ? 1 : -1);
    checks++;
    if ({c0_rdy[d], c1_rdy[d]} !== ((w == 0) ? 2'b10 : 2'b01) || sdr_req[d] !== 1'b0 || terr[d] !== 1'b0 || busy[d] !== 1'b1)
      $display("FAIL done d%0d: rdy=%b%b req=%b terr=%b busy=%b, want client %0d req0 terr0 busy1",
               d, c0_rdy[d], c1_rdy[d], sdr_req[d], terr[d], busy[d], w);
    else passed++;
    checks++;
    if (c0_data[d] !== exp_d[d][0] || c1_data[d] !== exp_d[d][1])
      $display("FAIL data d%0d: c0=%h c1=%h, want %h %h", d, c0_data[d], c1_data[d], exp_d[d][0], exp_d[d][1]);
    else passed++;
    @(posedge clk); #1;
    sdr_rdy[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b0 || c0_rdy[d] !== 1'b0 || c1_rdy[d] !== 1'b0 || sdr_req[d] !== 1'b0)
      $display("FAIL recover d%0d: busy=%b rdy=%b%b req=%b, want all 0", d, busy[d], c0_rdy[d], c1_rdy[d], sdr_req[d]);
    else passed++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({sdr_req[d], busy[d], terr[d], c0_rdy[d], c1_rdy[d]} !== 5'b0)
        $display("FAIL reset_ctl d%0d: req,busy,terr,rdy0,rdy1=%b%b%b%b%b, want 00000",
                 d, sdr_req[d], busy[d], terr[d], c0_rdy[d], c1_rdy[d]);
      else passed++;
      checks++;
      if (sdr_addr[d] !== '0 || c0_data[d] !== '0 || c1_data[d] !== '0)
        $display("FAIL reset_dat d%0d: addr=%h c0=%h c1=%h, want 0", d, sdr_addr[d], c0_data[d], c1_data[d]);
      else passed++;
    end
  endtask

  task automatic test_single();
    int got;
    c0_req[0] = 1'b1; c0_addr[0] = 25'h0012340;
    txn(0, 5, 64'h1122334455667788, 1'b1, 1'b0, got);
    checks++;
    if (got !== 0) $display("FAIL single_client: got=%0d, want 0", got); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (c0_rdy[0] !== 1'b0 || c1_rdy[0] !== 1'b0 || sdr_req[0] !== 1'b0)
        $display("FAIL single_quiet: rdy=%b%b req=%b, want 000", c0_rdy[0], c1_rdy[0], sdr_req[0]);
      else passed++;
    end
  endtask

  task automatic test_rr_tie();
    int got;
    int want[4] = '{0, 1, 0, 1};
    apply_reset();
    c0_req[0] = 1'b1; c0_addr[0] = AW'($urandom());
    c1_req[0] = 1'b1; c1_addr[0] = AW'($urandom());
    for (int k = 0; k < 4; k++) begin
      txn(0, $urandom_range(0, 6), {$urandom(), $urandom()}, 1'b0, 1'b0, got);
      checks++;
      if (got !== want[k]) $display("FAIL rr_order %0d: got=%0d, want %0d", k, got, want[k]); else passed++;
    end
    c0_req[0] = 1'b0; c1_req[0] = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int got;
    c0_req[1] = 1'b1; c0_addr[1] = AW'($urandom());
    c1_req[1] = 1'b1; c1_addr[1] = AW'($urandom());
    for (int k = 0; k < 4; k++) begin
      txn(1, $urandom_range(0, 6), {$urandom(), $urandom()}, 1'b0, 1'b0, got);
      checks++;
      if (got !== 0) $display("FAIL fixed_prio %0d: got=%0d, want 0", k, got); else passed++;
    end
    c0_req[1] = 1'b0;
    txn(1, 3, {$urandom(), $urandom()}, 1'b1, 1'b0, got);
    checks++;
    if (got !== 1) $display("FAIL fixed_c1_after_drop: got=%0d, want 1", got); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    int got;
    c1_req[0] = 1'b1; c1_addr[0] = AW'($urandom());
    last_g[0] = 1;
    @(posedge clk); #1;
    checks++;
    if (sdr_req[0] !== 1'b1 || sdr_addr[0] !== c1_addr[0])
      $display("FAIL tmo_grant: req=%b addr=%h, want 1 %h", sdr_req[0], sdr_addr[0], c1_addr[0]);
    else passed++;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (c1_rdy[0] === 1'b1) seen = 1'b1;
      else if (terr[0] !== 1'b0 || sdr_req[0] !== 1'b1) begin
        checks++;
        $display("FAIL tmo_early cyc %0d: terr=%b req=%b, want 0 1", n, terr[0], sdr_req[0]);
      end
    end
    checks++;
    if (!seen || n !== 16) $display("FAIL tmo_cycles: seen=%b after %0d, want 1 after 16", seen, n); else passed++;
    exp_d[0][1] = '1;
    checks++;
    if (c1_data[0] !== exp_d[0][1] || terr[0] !== 1'b1 || sdr_req[0] !== 1'b0 || c0_rdy[0] !== 1'b0)
      $display("FAIL tmo_result: c1=%h terr=%b req=%b rdy0=%b, want ones 1 0 0", c1_data[0], terr[0], sdr_req[0], c0_rdy[0]);
    else passed++;
    c1_req[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (terr[0] !== 1'b0 || busy[0] !== 1'b0) $display("FAIL tmo_pulse: terr=%b busy=%b, want 0 0", terr[0], busy[0]); else passed++;
    c0_req[0] = 1'b1; c0_addr[0] = AW'($urandom());
    txn(0, 2, {$urandom(), $urandom()}, 1'b1, 1'b0, got);
    checks++;
    if (got !== 0) $display("FAIL tmo_next: got=%0d, want 0", got); else passed++;
  endtask

  task automatic test_coincide();
    int got;
    c0_req[0] = 1'b1; c0_addr[0] = AW'($urandom());
    // rdy lands on the 16th WAIT edge, the same edge the timer expires
    txn(0, 15, 64'hA5A5_0F0F_1234_5678, 1'b1, 1'b0, got);
    checks++;
    if (got !== 0 || c0_data[0] !== 64'hA5A5_0F0F_1234_5678)
      $display("FAIL coincide: got=%0d data=%h, want 0 a5a50f0f12345678", got, c0_data[0]);
    else passed++;
  endtask

  task automatic test_random();
    int got;
    int pat;
    for (int k = 0; k < 24; k++) begin
      pat = $urandom_range(1, 3);
      c0_req[0] = pat[0]; c1_req[0] = pat[1];
      c0_addr[0] = AW'($urandom()); c1_addr[0] = AW'($urandom());
      txn(0, $urandom_range(0, 12), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), got);
    end
    c0_req[0] = 1'b0; c1_req[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got;
    c0_req[0] = 1'b1; c0_addr[0] = AW'($urandom());
    c1_req[0] = 1'b1; c1_addr[0] = AW'($urandom());
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sdr_req[0] !== 1'b0 || busy[0] !== 1'b0)
      $display("FAIL rst_async: req=%b busy=%b, want 0 0", sdr_req[0], busy[0]);
    else passed++;
    model_reset();
    c0_req[0] = 1'b0; c1_req[0] = 1'b0;
    sdr_rdy[0] = 1'b1; sdr_data[0] = {$urandom(), $urandom()};
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (c0_rdy[0] !== 1'b0 || c1_rdy[0] !== 1'b0 || c0_data[0] !== '0 || c1_data[0] !== '0)
        $display("FAIL rst_hold: rdy=%b%b c0=%h c1=%h, want 00 0 0", c0_rdy[0], c1_rdy[0], c0_data[0], c1_data[0]);
      else passed++;
    end
    sdr_rdy[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (c0_rdy[0] !== 1'b0 || c1_rdy[0] !== 1'b0 || sdr_req[0] !== 1'b0)
      $display("FAIL rst_replay: rdy=%b%b req=%b, want 000", c0_rdy[0], c1_rdy[0], sdr_req[0]);
    else passed++;
    c0_req[0] = 1'b1; c1_req[0] = 1'b1;
    txn(0, 1, {$urandom(), $urandom()}, 1'b1, 1'b0, got);
    checks++;
    if (got !== 0) $display("FAIL rst_first_tie: got=%0d, want 0", got); else passed++;
    c1_req[0] = 1'b0;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_rr_tie();
    test_fixed_prio();
    test_timeout();
    test_coincide();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end

endmodule
